// File: rtl/hdb3enc.sv
// HDB3 / AMI line encoder for the E1 transmit path: NRZ serin in, dual-rail pos/neg out.
// Optional all-ones AIS override is compiled in when HDB3ENC_AIS_EN is defined.
module hdb3enc (
  input  logic clk2,
  input  logic rst,
  input  logic serin,
  input  logic amisel,
  input  logic ais,
  output logic pos,
  output logic neg,
  output logic vflag
);

  typedef enum logic [1:0] {
    TAG_DATA = 2'd0,
    TAG_B    = 2'd1,
    TAG_V    = 2'd2
  } tag_t;

  logic [3:0] dbit;
  tag_t       dtag [4];
  logic [1:0] zc;
  logic       parity;
  logic       lastpol;
  logic       din;
  logic       trigger;
  logic       d3mark;
  logic       d3viol;
  logic       pareff;

`ifdef HDB3ENC_AIS_EN
  assign din = ais | serin;
`else
  logic unused_ais;
  assign unused_ais = ais;
  assign din = serin;
`endif

  // The B/space decision must count the mark leaving d3 on this same edge,
  // and a V leaving d3 now means the count restarts from zero.
  always_comb begin
    d3mark  = (dtag[3] == TAG_B) || ((dtag[3] == TAG_DATA) && dbit[3]);
    d3viol  = (dtag[3] == TAG_V);
    pareff  = d3viol ? 1'b0 : (parity ^ d3mark);
    trigger = !amisel && !din && (zc == 2'd3);
  end

  always_ff @(posedge clk2) begin
    if (rst) begin
      dbit    <= '0;
      dtag    <= '{TAG_DATA, TAG_DATA, TAG_DATA, TAG_DATA};
      zc      <= '0;
      parity  <= 1'b0;
      lastpol <= 1'b0;
      pos     <= 1'b0;
      neg     <= 1'b0;
      vflag   <= 1'b0;
    end else begin
      dbit    <= {dbit[2:0], din};
      dtag[0] <= trigger ? TAG_V : TAG_DATA;
      dtag[1] <= dtag[0];
      dtag[2] <= dtag[1];
      dtag[3] <= (trigger && !pareff) ? TAG_B : dtag[2];

      if (din || trigger)
        zc <= '0;
      else if (zc != 2'd3)
        zc <= zc + 2'd1;

      if (d3viol)
        parity <= 1'b0;
      else if (d3mark)
        parity <= ~parity;

      // lastpol = 1 means the previous mark went out on pos
      if (d3mark)
        lastpol <= ~lastpol;

      pos   <= (d3mark && !lastpol) || (d3viol && lastpol);
      neg   <= (d3mark && lastpol)  || (d3viol && !lastpol);
      vflag <= d3viol;
    end
  end

endmodule

// File: tb/tb_hdb3enc.sv
// Self-checking bench for hdb3enc: directed patterns plus a long random stream
// compared against a symbol-list reference model.
module tb_hdb3enc;

  logic clk2 = 1'b0;
  logic rst = 1'b1;
  logic serin = 1'b0;
  logic amisel = 1'b0;
  logic ais = 1'b0;
  logic pos;
  logic neg;
  logic vflag;

  int ncomp = 0;
  int nfail = 0;

  // Reference model: one entry per input bit (0 space, 1 data one, 2 B, 3 V)
  int msym[$];
  int mlast;

  hdb3enc dut (
    .clk2(clk2),
    .rst(rst),
    .serin(serin),
    .amisel(amisel),
    .ais(ais),
    .pos(pos),
    .neg(neg),
    .vflag(vflag)
  );

  always #5 clk2 = ~clk2;

  task automatic tick(input logic s, input logic a, output int sym, output logic v);
    serin  = s;
    amisel = a;
    @(posedge clk2);
    #1;
    sym = (pos && neg) ? 2 : (pos ? 1 : (neg ? -1 : 0));
    v   = vflag;
  endtask

  task automatic apply_reset;
    rst   = 1'b1;
    serin = 1'b0;
    repeat (2) @(posedge clk2);
    #1;
    rst = 1'b0;
  endtask

  task automatic model_reset;
    msym.delete();
    mlast = -1;
  endtask

  task automatic model_step(input logic b, input logic am, output int esym, output logic ev);
    int n;
    int marks;
    n = msym.size();
    msym.push_back(b ? 1 : 0);
    if (!b && !am && n >= 3 && msym[n-1] == 0 && msym[n-2] == 0 && msym[n-3] == 0) begin
      msym[n] = 3;
      marks = 0;
      for (int j = n - 4; j >= 0; j--) begin
        if (msym[j] == 3) break;
        if (msym[j] == 1 || msym[j] == 2) marks++;
      end
      if (marks % 2 == 0) msym[n-3] = 2;
    end
    esym = 0;
    ev   = 1'b0;
    if (n >= 4) begin
      case (msym[n-4])
        1, 2: begin
          mlast = -mlast;
          esym  = mlast;
        end
        3: begin
          esym = mlast;
          ev   = 1'b1;
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_reset;
    int sym;
    logic v;
    int exp [5] = '{0, 0, 0, 0, 1};
    apply_reset();
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, sym, v);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk2);
      #1;
      ncomp++;
      if ({pos, neg, vflag} !== 3'b000) begin
        nfail++;
        $display("[TB] FAIL reset_outputs cycle %0d: pos/neg/vflag=%b, expected 000", i, {pos, neg, vflag});
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0, sym, v);
      ncomp++;
      if (sym !== exp[i] || v !== 1'b0) begin
        nfail++;
        $display("[TB] FAIL reset_flush tick %0d: sym=%0d v=%b, expected sym=%0d v=0", i, sym, v, exp[i]);
      end
    end
  endtask

  task automatic test_hdb3_pattern;
    int sym;
    logic v;
    logic din [15] = '{1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    int   exp [15] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, -1, 1, -1, 0, 0, -1};
    logic vex [15] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
    apply_reset();
    for (int i = 0; i < 15; i++) begin
      tick(din[i], 1'b0, sym, v);
      ncomp++;
      if (sym !== exp[i] || v !== vex[i]) begin
        nfail++;
        $display("[TB] FAIL hdb3_pattern tick %0d: sym=%0d v=%b, expected sym=%0d v=%b", i, sym, v, exp[i], vex[i]);
      end
    end
  endtask

  task automatic test_all_zeros;
    int sym;
    logic v;
    int exp [16] = '{0, 0, 0, 0, 1, 0, 0, 1, -1, 0, 0, -1, 1, 0, 0, 1};
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      tick(1'b0, 1'b0, sym, v);
      ncomp++;
      if (sym !== exp[i] || v !== ((i % 4 == 3) && i >= 7)) begin
        nfail++;
        $display("[TB] FAIL all_zeros tick %0d: sym=%0d v=%b, expected sym=%0d v=%b", i, sym, v, exp[i], (i % 4 == 3) && i >= 7);
      end
    end
  endtask

  task automatic test_ami;
    int sym;
    logic v;
    logic din [12] = '{1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    int   exp [12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, -1, 1};
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      tick(din[i], 1'b1, sym, v);
      ncomp++;
      if (sym !== exp[i] || v !== 1'b0) begin
        nfail++;
        $display("[TB] FAIL ami tick %0d: sym=%0d v=%b, expected sym=%0d v=0", i, sym, v, exp[i]);
      end
    end
  endtask

  task automatic test_reset_midrun;
    int sym;
    logic v;
    int exp [8] = '{0, 0, 0, 0, 1, 0, 0, 1};
    apply_reset();
    tick(1'b1, 1'b0, sym, v);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, sym, v);
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b0, sym, v);
      ncomp++;
      if (sym !== exp[i] || v !== (i == 7)) begin
        nfail++;
        $display("[TB] FAIL reset_midrun tick %0d: sym=%0d v=%b, expected sym=%0d v=%b", i, sym, v, exp[i], i == 7);
      end
    end
  endtask

`ifdef HDB3ENC_AIS_EN
  task automatic test_ais;
    int sym;
    logic v;
    logic din [15] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 1, 1};
    int   exp [15] = '{0, 0, 0, 0, 1, -1, 1, -1, 1, -1, 1, -1, 1, 0, -1};
    apply_reset();
    for (int i = 0; i < 15; i++) begin
      ais = (i < 8);
      tick(din[i], 1'b0, sym, v);
      ncomp++;
      if (sym !== exp[i] || v !== 1'b0) begin
        nfail++;
        $display("[TB] FAIL ais tick %0d: sym=%0d v=%b, expected sym=%0d v=0", i, sym, v, exp[i]);
      end
    end
    ais = 1'b0;
  endtask
`endif

  task automatic test_random;
    int sym;
    int esym;
    logic v;
    logic ev;
    logic b;
    logic am;
    int spaces;
    int lastv;
    apply_reset();
    model_reset();
    spaces = 0;
    lastv  = 0;
    for (int i = 0; i < 10000; i++) begin
      b = ($urandom_range(0, 3) == 0);
      model_step(b, 1'b0, esym, ev);
      tick(b, 1'b0, sym, v);
      ncomp++;
      if (sym !== esym || v !== ev) begin
        nfail++;
        $display("[TB] FAIL random_hdb3 tick %0d: sym=%0d v=%b, expected sym=%0d v=%b", i, sym, v, esym, ev);
      end
      if (i >= 8) begin
        spaces = (sym == 0) ? spaces + 1 : 0;
        ncomp++;
        if (spaces >= 4) begin
          nfail++;
          $display("[TB] FAIL random_space_run tick %0d: run=%0d, expected below 4", i, spaces);
        end
      end
      if (v) begin
        if (lastv != 0) begin
          ncomp++;
          if (sym !== -lastv) begin
            nfail++;
            $display("[TB] FAIL random_v_alternate tick %0d: sym=%0d, expected %0d", i, sym, -lastv);
          end
        end
        lastv = sym;
      end
    end
    am = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (i % 50 == 0) am = $urandom_range(0, 1);
      b = ($urandom_range(0, 3) == 0);
      model_step(b, am, esym, ev);
      tick(b, am, sym, v);
      ncomp++;
      if (sym !== esym || v !== ev) begin
        nfail++;
        $display("[TB] FAIL random_mixed tick %0d: sym=%0d v=%b, expected sym=%0d v=%b", i, sym, v, esym, ev);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hdb3_pattern();
    test_all_zeros();
    test_ami();
    test_reset_midrun();
`ifdef HDB3ENC_AIS_EN
    test_ais();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
